// File: rtl/comparator_minmax_ctrl.sv
// -----------------------------------------------------------------------------
// comparator_minmax_ctrl
//   Finds the maximum and minimum of a frame of 8-bit samples, sharing one
//   comparator_8bit across the max and min updates. Samples arrive on a
//   valid/ready stream. A one-cycle done pulse marks valid results.
//
//   Ports:
//     clk       system clock (rising edge)
//     rst_n     asynchronous active-low reset
//     start     begin a frame (only looked at in IDLE)
//     len       frame length, latched on an accepted start
//     in_valid  sample valid
//     in_data   sample value
//     in_ready  sample accepted this cycle (high only in LOAD)
//     busy      high in every state except IDLE
//     done      one-cycle result pulse
//     err       set with done for a zero-length frame
//     max_out   frame maximum
//     min_out   frame minimum
//     max_idx   (MINMAX_INDEX_EN) 0-based position of the maximum
//     min_idx   (MINMAX_INDEX_EN) 0-based position of the minimum
//
//   Optional feature macro: MINMAX_INDEX_EN adds the max_idx/min_idx outputs.
// -----------------------------------------------------------------------------

module comparator_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_gt_b,
  output logic       a_lt_b,
  output logic       a_eq_b
);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);
endmodule

module comparator_minmax_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef MINMAX_INDEX_EN
  output logic [LEN_W-1:0] max_idx,
  output logic [LEN_W-1:0] min_idx,
`endif
  output logic [7:0]       max_out,
  output logic [7:0]       min_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [7:0]       sample_r;
  logic [7:0]       max_r;
  logic [7:0]       min_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
`ifdef MINMAX_INDEX_EN
  logic [LEN_W-1:0] sample_idx_r;
  logic [LEN_W-1:0] max_idx_r;
  logic [LEN_W-1:0] min_idx_r;
`endif

  logic [7:0] cmp_a_s;
  logic [7:0] cmp_b_s;
  logic       cmp_gt_s;
  logic       cmp_lt_s;
  logic       cmp_eq_s;

  // Comparator operand mux: current sample against max or min, zero otherwise
  always_comb begin
    cmp_a_s = 8'h00;
    cmp_b_s = 8'h00;
    case (state_r)
      CMP_MAX: begin
        cmp_a_s = sample_r;
        cmp_b_s = max_r;
      end
      CMP_MIN: begin
        cmp_a_s = sample_r;
        cmp_b_s = min_r;
      end
      default: begin
        cmp_a_s = 8'h00;
        cmp_b_s = 8'h00;
      end
    endcase
  end

  comparator_8bit u_cmp (
    .a      (cmp_a_s),
    .b      (cmp_b_s),
    .a_gt_b (cmp_gt_s),
    .a_lt_b (cmp_lt_s),
    .a_eq_b (cmp_eq_s)
  );

  // Sequencer FSM with registered outputs; in_ready_r tracks state==LOAD exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      len_r      <= '0;
      cnt_r      <= '0;
      sample_r   <= 8'h00;
      max_r      <= 8'h00;
      min_r      <= 8'h00;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef MINMAX_INDEX_EN
      sample_idx_r <= '0;
      max_idx_r    <= '0;
      min_idx_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (len != '0) begin
              len_r      <= len;
              cnt_r      <= '0;
              err_r      <= 1'b0;
              in_ready_r <= 1'b1;
              state_r    <= LOAD;
            end else begin
              // Empty frame: report immediately, keep previous max/min
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            sample_r <= in_data;
            cnt_r    <= cnt_r + LEN_W'(1);
`ifdef MINMAX_INDEX_EN
            sample_idx_r <= cnt_r;
`endif
            if (cnt_r == '0) begin
              // First sample seeds both extremes without a compare
              max_r <= in_data;
              min_r <= in_data;
`ifdef MINMAX_INDEX_EN
              max_idx_r <= '0;
              min_idx_r <= '0;
`endif
              if (len_r == LEN_W'(1)) begin
                in_ready_r <= 1'b0;
                done_r     <= 1'b1;
                state_r    <= DONE;
              end
            end else begin
              in_ready_r <= 1'b0;
              state_r    <= CMP_MAX;
            end
          end
        end
        CMP_MAX: begin
          // Strictly greater only: ties keep the earlier winner
          if (cmp_gt_s && !cmp_eq_s) begin
            max_r <= sample_r;
`ifdef MINMAX_INDEX_EN
            max_idx_r <= sample_idx_r;
`endif
          end
          state_r <= CMP_MIN;
        end
        CMP_MIN: begin
          if (cmp_lt_s && !cmp_eq_s) begin
            min_r <= sample_r;
`ifdef MINMAX_INDEX_EN
            min_idx_r <= sample_idx_r;
`endif
          end
          if (cnt_r == len_r) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= LOAD;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign max_out  = max_r;
  assign min_out  = min_r;
`ifdef MINMAX_INDEX_EN
  assign max_idx  = max_idx_r;
  assign min_idx  = min_idx_r;
`endif

endmodule

// File: tb/tb_comparator_minmax_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comparator_minmax_ctrl
//   Directed self-checking bench for comparator_minmax_ctrl. Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------

module tb_comparator_minmax_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] max_out;
  logic [7:0] min_out;
`ifdef MINMAX_INDEX_EN
  logic [7:0] max_idx;
  logic [7:0] min_idx;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rdy_bad = 0;

  logic [7:0] samp[$];

  comparator_minmax_ctrl #(.LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
`ifdef MINMAX_INDEX_EN
    .max_idx  (max_idx),
    .min_idx  (min_idx),
`endif
    .max_out  (max_out),
    .min_out  (min_out)
  );

  always #5 clk = ~clk;

  // Handshake and done-pulse counters
  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // in_ready must never be high outside an active LOAD (idle or done)
  always @(negedge clk) begin
    if (in_ready && (!busy || done)) rdy_bad <= rdy_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one frame from samp; returns falling edges from start to done
  task automatic run_frame(input logic [7:0] n, input bit rnd, output int lat);
    int  idx;
    bit  acc;
    idx   = 0;
    start = 1'b1;
    len   = n;
    @(negedge clk);
    lat   = 1;
    start = 1'b0;
    while (!done && lat < 300) begin
      if (idx < samp.size()) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = samp[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (rnd) begin
        start = (lat == 4 || lat == 9);
        len   = 8'd2;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      lat++;
      if (acc) idx++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int hs0;
    int dn0;

    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_max", max_out, 0);
    check("rst_min", min_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: len=5
    samp = '{8'd50, 8'd20, 8'd200, 8'd15, 8'd100};
    dn0 = done_cnt;
    run_frame(8'd5, 1'b0, lat);
    check("t1_done", done, 1);
    check("t1_lat", lat, 14);
    check("t1_max", max_out, 200);
    check("t1_min", min_out, 15);
    check("t1_err", err, 0);
    check("t1_busy", busy, 1);
`ifdef MINMAX_INDEX_EN
    check("t1_max_idx", max_idx, 2);
    check("t1_min_idx", min_idx, 3);
`endif
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_done_cnt", done_cnt - dn0, 1);
    check("t1_hold_max", max_out, 200);

    // 2: len=1
    samp = '{8'hA5};
    run_frame(8'd1, 1'b0, lat);
    check("t2_done", done, 1);
    check("t2_lat", lat, 2);
    check("t2_max", max_out, 8'hA5);
    check("t2_min", min_out, 8'hA5);
    check("t2_err", err, 0);
    @(negedge clk);

    // 3: len=0
    samp = {};
    run_frame(8'd0, 1'b0, lat);
    check("t3_done", done, 1);
    check("t3_lat", lat, 1);
    check("t3_err", err, 1);
    check("t3_max", max_out, 8'hA5);
    check("t3_min", min_out, 8'hA5);
    @(negedge clk);
    check("t3_err_hold", err, 1);

    // 4: len=4 with ties
    samp = '{8'd100, 8'd100, 8'd255, 8'd255};
    run_frame(8'd4, 1'b0, lat);
    check("t4_done", done, 1);
    check("t4_lat", lat, 11);
    check("t4_err", err, 0);
    check("t4_max", max_out, 255);
    check("t4_min", min_out, 100);
`ifdef MINMAX_INDEX_EN
    check("t4_max_idx", max_idx, 2);
    check("t4_min_idx", min_idx, 0);
`endif
    @(negedge clk);

    // 5: len=6, random in_valid, start pulsed while busy
    samp = '{8'd10, 8'd240, 8'd3, 8'd77, 8'd128, 8'd200};
    hs0 = hs_cnt;
    dn0 = done_cnt;
    run_frame(8'd6, 1'b1, lat);
    check("t5_done", done, 1);
    check("t5_max", max_out, 240);
    check("t5_min", min_out, 3);
    check("t5_err", err, 0);
    @(negedge clk);
    check("t5_handshakes", hs_cnt - hs0, 6);
    check("t5_done_cnt", done_cnt - dn0, 1);
    check("t5_rdy_only_load", rdy_bad, 0);
    check("t5_idle", busy, 0);

    // 6: reset during CMP_MAX of sample 3
    dn0      = done_cnt;
    start    = 1'b1;
    len      = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd30;
    @(negedge clk);
    in_data  = 8'd40;
    repeat (3) @(negedge clk);
    in_data  = 8'd50;
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_max", max_out, 0);
    check("t6_rst_min", min_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_done", done_cnt - dn0, 0);
    samp = '{8'd7, 8'd9, 8'd8};
    run_frame(8'd3, 1'b0, lat);
    check("t6_done", done, 1);
    check("t6_lat", lat, 8);
    check("t6_max", max_out, 9);
    check("t6_min", min_out, 7);
`ifdef MINMAX_INDEX_EN
    check("t6_max_idx", max_idx, 1);
    check("t6_min_idx", min_idx, 0);
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
